// File: rtl/id_operand_stage.sv
// ToruMIPS decode/operand-fetch stage: decodes IF/ID, requests register reads, resolves
// operands with EX/MEM forwarding, detects load-use hazards and fills the ID/EX register.
module id_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [31:0]        if_inst,
  input  logic [31:0]        if_pc,
  input  logic               stall_in,
  input  logic               flush,
  output logic               re1,
  output logic               re2,
  output logic [RADDR_W-1:0] raddr1,
  output logic [RADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0]  rdata1,
  input  logic [DATA_W-1:0]  rdata2,
  input  logic               ex_wreg_i,
  input  logic [RADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wreg_i,
  input  logic [RADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  output logic               stall_req,
  output logic               ex_valid,
  output logic [3:0]         ex_aluop,
  output logic [DATA_W-1:0]  ex_src1,
  output logic [DATA_W-1:0]  ex_src2,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_wd,
  output logic               ex_wreg,
  output logic [31:0]        ex_pc,
  output logic               ex_inst_err
);

  localparam logic [3:0] AluNop  = 4'd0;
  localparam logic [3:0] AluAddu = 4'd1;
  localparam logic [3:0] AluSubu = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluOr   = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSlt  = 4'd6;
  localparam logic [3:0] AluLui  = 4'd7;
  localparam logic [3:0] AluLw   = 4'd8;
  localparam logic [3:0] AluSw   = 4'd9;

  // Operand-shape classes selecting how src1/src2/store_data are formed
  localparam logic [2:0] KNone = 3'd0;
  localparam logic [2:0] KReg  = 3'd1;
  localparam logic [2:0] KZext = 3'd2;
  localparam logic [2:0] KSext = 3'd3;
  localparam logic [2:0] KLui  = 3'd4;
  localparam logic [2:0] KSw   = 3'd5;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [RADDR_W-1:0] rs;
  logic [RADDR_W-1:0] rt;
  logic [RADDR_W-1:0] rd;
  logic [15:0]        imm;
  logic               unused_shamt;

  assign op           = if_inst[31:26];
  assign rs           = if_inst[25:21];
  assign rt           = if_inst[20:16];
  assign rd           = if_inst[15:11];
  assign funct        = if_inst[5:0];
  assign imm          = if_inst[15:0];
  assign unused_shamt = ^if_inst[10:6];

  logic [3:0]         dec_aluop;
  logic [2:0]         dec_kind;
  logic               dec_re1;
  logic               dec_re2;
  logic [RADDR_W-1:0] dec_ra1;
  logic [RADDR_W-1:0] dec_ra2;
  logic [RADDR_W-1:0] dec_wd;
  logic               dec_wreg;
  logic               dec_err;
  logic [DATA_W-1:0]  op1;
  logic [DATA_W-1:0]  op2;
  logic [DATA_W-1:0]  dec_src1;
  logic [DATA_W-1:0]  dec_src2;
  logic [DATA_W-1:0]  dec_store;

  function automatic logic [DATA_W-1:0] resolve(input logic [RADDR_W-1:0] a,
                                                input logic [DATA_W-1:0]  rf);
    if (a == '0)                                         return '0;
    else if (ex_wreg_i && ex_wd_i == a && !ex_is_load_i) return ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == a)                return mem_wdata_i;
    else                                                 return rf;
  endfunction

  always_comb begin
    dec_aluop = AluNop;
    dec_kind  = KNone;
    dec_wd    = '0;
    dec_wreg  = 1'b0;
    dec_err   = 1'b0;
    unique case (op)
      6'b000000: begin
        unique case (funct)
          6'b100001: dec_aluop = AluAddu;
          6'b100011: dec_aluop = AluSubu;
          6'b100100: dec_aluop = AluAnd;
          6'b100101: dec_aluop = AluOr;
          6'b100110: dec_aluop = AluXor;
          6'b101010: dec_aluop = AluSlt;
          default:   dec_aluop = AluNop;
        endcase
        if (dec_aluop != AluNop) begin
          dec_kind = KReg;
          dec_wd   = rd;
          dec_wreg = 1'b1;
        end else begin
          // The all-zero word is the canonical NOP, not an illegal instruction
          dec_err = (if_inst != 32'h0);
        end
      end
      6'b001100: begin dec_aluop = AluAnd;  dec_kind = KZext; dec_wd = rt; dec_wreg = 1'b1; end
      6'b001101: begin dec_aluop = AluOr;   dec_kind = KZext; dec_wd = rt; dec_wreg = 1'b1; end
      6'b001110: begin dec_aluop = AluXor;  dec_kind = KZext; dec_wd = rt; dec_wreg = 1'b1; end
      6'b001001: begin dec_aluop = AluAddu; dec_kind = KSext; dec_wd = rt; dec_wreg = 1'b1; end
      6'b100011: begin dec_aluop = AluLw;   dec_kind = KSext; dec_wd = rt; dec_wreg = 1'b1; end
      6'b001111: begin dec_aluop = AluLui;  dec_kind = KLui;  dec_wd = rt; dec_wreg = 1'b1; end
      6'b101011: begin dec_aluop = AluSw;   dec_kind = KSw; end
      default:   dec_err = 1'b1;
    endcase

    dec_re1 = if_valid && (dec_kind == KReg || dec_kind == KZext ||
                           dec_kind == KSext || dec_kind == KSw);
    dec_re2 = if_valid && (dec_kind == KReg || dec_kind == KSw);
    dec_ra1 = dec_re1 ? rs : '0;
    dec_ra2 = dec_re2 ? rt : '0;

    op1 = resolve(dec_ra1, rdata1);
    op2 = resolve(dec_ra2, rdata2);

    dec_src1  = '0;
    dec_src2  = '0;
    dec_store = '0;
    case (dec_kind)
      KReg:  begin dec_src1 = op1; dec_src2 = op2; end
      KZext: begin dec_src1 = op1; dec_src2 = {{(DATA_W-16){1'b0}}, imm}; end
      KSext: begin dec_src1 = op1; dec_src2 = {{(DATA_W-16){imm[15]}}, imm}; end
      KLui:  dec_src2 = {imm, {(DATA_W-16){1'b0}}};
      KSw: begin
        dec_src1  = op1;
        dec_src2  = {{(DATA_W-16){imm[15]}}, imm};
        dec_store = op2;
      end
      default: ;
    endcase
  end

  assign re1    = dec_re1;
  assign re2    = dec_re2;
  assign raddr1 = dec_ra1;
  assign raddr2 = dec_ra2;

  assign stall_req = if_valid && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                     ((dec_re1 && dec_ra1 == ex_wd_i) || (dec_re2 && dec_ra2 == ex_wd_i));

  always_ff @(posedge clk) begin
    if (rst || flush || (!stall_in && (stall_req || !if_valid))) begin
      ex_valid      <= 1'b0;
      ex_aluop      <= AluNop;
      ex_src1       <= '0;
      ex_src2       <= '0;
      ex_store_data <= '0;
      ex_wd         <= '0;
      ex_wreg       <= 1'b0;
      ex_pc         <= '0;
      ex_inst_err   <= 1'b0;
    end else if (!stall_in) begin
      ex_valid      <= 1'b1;
      ex_aluop      <= dec_aluop;
      ex_src1       <= dec_src1;
      ex_src2       <= dec_src2;
      ex_store_data <= dec_store;
      ex_wd         <= dec_wd;
      ex_wreg       <= dec_wreg;
      ex_pc         <= if_pc;
      ex_inst_err   <= dec_err;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed-vector bench for id_operand_stage with hand-computed expectations.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        stall_in;
  logic        flush;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_is_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        stall_req;
  logic        ex_valid;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_pc;
  logic        ex_inst_err;

  int errors = 0;
  int checks = 0;

  id_operand_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .stall_in(stall_in), .flush(flush),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stall_req(stall_req), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_store_data(ex_store_data),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_pc(ex_pc), .ex_inst_err(ex_inst_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_fwd;
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  initial begin
    rst = 1; if_valid = 0; if_inst = 0; if_pc = 0; stall_in = 0; flush = 0;
    rdata1 = 0; rdata2 = 0;
    clear_fwd();
    tick();
    tick();
    check("rst_valid", ex_valid, 0);
    check("rst_aluop", ex_aluop, 0);
    check("rst_wreg", ex_wreg, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_err", ex_inst_err, 0);
    rst = 0;

    // ADDU $3,$1,$2
    if_valid = 1; if_pc = 32'h100; if_inst = rtype(5'd1, 5'd2, 5'd3, 6'b100001);
    rdata1 = 5; rdata2 = 7;
    #1;
    check("addu_re1", re1, 1);
    check("addu_raddr2", raddr2, 2);
    check("addu_stall", stall_req, 0);
    tick();
    check("addu_aluop", ex_aluop, 1);
    check("addu_src1", ex_src1, 5);
    check("addu_src2", ex_src2, 7);
    check("addu_wd", ex_wd, 3);
    check("addu_wreg", ex_wreg, 1);
    check("addu_valid", ex_valid, 1);
    check("addu_pc", ex_pc, 32'h100);

    // ORI $4,$0,0x8000 -- $0 must read as zero even with garbage rdata
    if_inst = itype(6'b001101, 5'd0, 5'd4, 16'h8000); rdata1 = 32'hDEAD; if_pc = 32'h104;
    #1;
    check("ori_re1", re1, 1);
    check("ori_raddr1", raddr1, 0);
    check("ori_re2", re2, 0);
    tick();
    check("ori_aluop", ex_aluop, 4);
    check("ori_src1", ex_src1, 0);
    check("ori_src2", ex_src2, 32'h0000_8000);
    check("ori_wd", ex_wd, 4);

    // ADDIU $4,$0,0x8000 -> sign-extended
    if_inst = itype(6'b001001, 5'd0, 5'd4, 16'h8000);
    tick();
    check("addiu_aluop", ex_aluop, 1);
    check("addiu_src2", ex_src2, 32'hFFFF_8000);

    // Forwarding priority on $5
    if_inst = rtype(5'd5, 5'd0, 5'd8, 6'b100001); rdata1 = 1;
    ex_wreg_i = 1; ex_wd_i = 5; ex_wdata_i = 32'hAA;
    mem_wreg_i = 1; mem_wd_i = 5; mem_wdata_i = 32'hBB;
    tick();
    check("fwd_ex", ex_src1, 32'hAA);
    ex_wreg_i = 0;
    tick();
    check("fwd_mem", ex_src1, 32'hBB);
    mem_wreg_i = 0;
    tick();
    check("fwd_rf", ex_src1, 1);

    // Load-use: LW $6 in EX, SUBU $7,$6,$1 in ID
    clear_fwd();
    ex_wreg_i = 1; ex_wd_i = 6; ex_is_load_i = 1; ex_wdata_i = 32'h9999;
    if_inst = rtype(5'd6, 5'd1, 5'd7, 6'b100011); if_pc = 32'h200;
    rdata1 = 32'h1; rdata2 = 32'h3;
    #1;
    check("lu_stall", stall_req, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_wreg", ex_wreg, 0);
    clear_fwd();
    mem_wreg_i = 1; mem_wd_i = 6; mem_wdata_i = 32'h1234;
    #1;
    check("lu_stall_clear", stall_req, 0);
    tick();
    check("lu_src1", ex_src1, 32'h1234);
    check("lu_src2", ex_src2, 3);
    check("lu_aluop", ex_aluop, 2);
    check("lu_wd", ex_wd, 7);

    // stall_in holds for 3 cycles while IF/ID changes
    clear_fwd();
    stall_in = 1; if_inst = rtype(5'd1, 5'd2, 5'd9, 6'b100110); if_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_aluop", ex_aluop, 2);
      check("hold_src1", ex_src1, 32'h1234);
      check("hold_pc", ex_pc, 32'h200);
    end
    flush = 1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_wreg", ex_wreg, 0);
    check("flush_aluop", ex_aluop, 0);
    flush = 0; stall_in = 0;

    // Undefined opcode and canonical NOP
    if_inst = 32'hFC00_0000;
    #1;
    check("undef_re1", re1, 0);
    tick();
    check("undef_err", ex_inst_err, 1);
    check("undef_wreg", ex_wreg, 0);
    check("undef_aluop", ex_aluop, 0);
    if_inst = 32'h0;
    tick();
    check("nop_err", ex_inst_err, 0);
    check("nop_aluop", ex_aluop, 0);
    check("nop_valid", ex_valid, 1);

    // LUI $9,0x1234
    if_inst = itype(6'b001111, 5'd3, 5'd9, 16'h1234);
    #1;
    check("lui_re1", re1, 0);
    tick();
    check("lui_aluop", ex_aluop, 7);
    check("lui_src1", ex_src1, 0);
    check("lui_src2", ex_src2, 32'h1234_0000);

    // SW $2,-4($1)
    if_inst = itype(6'b101011, 5'd1, 5'd2, 16'hFFFC); rdata1 = 32'h100; rdata2 = 32'h55;
    if_pc = 32'h400;
    tick();
    check("sw_aluop", ex_aluop, 9);
    check("sw_src1", ex_src1, 32'h100);
    check("sw_src2", ex_src2, 32'hFFFF_FFFC);
    check("sw_store", ex_store_data, 32'h55);
    check("sw_wreg", ex_wreg, 0);

    // Reset mid-stream
    rst = 1;
    tick();
    check("rst2_valid", ex_valid, 0);
    check("rst2_aluop", ex_aluop, 0);
    check("rst2_src1", ex_src1, 0);
    check("rst2_store", ex_store_data, 0);
    check("rst2_pc", ex_pc, 0);
    rst = 0;

    // Invalid IF/ID slot
    if_valid = 0;
    ex_wreg_i = 1; ex_wd_i = 1; ex_is_load_i = 1;
    #1;
    check("inv_re1", re1, 0);
    check("inv_stall", stall_req, 0);
    tick();
    check("inv_valid", ex_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
